// File: rtl/dfr_mem_arbiter.sv
// Purpose : arbitrates one single-port, 1-cycle-read-latency RAM between host, reservoir writer and multiplier.
// Latency : grant and RAM command in the request cycle; read data and x_rvalid one cycle after the grant.
// Backpres: requesters hold req until gnt; r/m have priority, host is forced through after HOST_MAX_WAIT denials.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   {h,r,m}_req/_wen/_addr/_din  access request, direction, address, write data
//   {r,m}_lock               keep the grant on the next cycle (burst)
//   {h,r,m}_gnt              access performed this cycle
//   {h,r,m}_rvalid, rdata    read return (rdata is ram_dout passthrough)
//   ram_wen/_addr/_din/_dout RAM port
//   host_starved             host wait counter saturated
// Optional: define DFR_MEM_ARB_STATS_EN to add stat_clr and the 32-bit grant/conflict counters.

module dfr_mem_arbiter #(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_req,
  input  logic                  h_wen,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_din,
  input  logic                  r_req,
  input  logic                  r_wen,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_din,
  input  logic                  r_lock,
  input  logic                  m_req,
  input  logic                  m_wen,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [DATA_WIDTH-1:0] m_din,
  input  logic                  m_lock,
  output logic                  h_gnt,
  output logic                  r_gnt,
  output logic                  m_gnt,
  output logic                  h_rvalid,
  output logic                  r_rvalid,
  output logic                  m_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
`ifdef DFR_MEM_ARB_STATS_EN
  input  logic                  stat_clr,
  output logic [31:0]           stat_h_cnt,
  output logic [31:0]           stat_r_cnt,
  output logic [31:0]           stat_m_cnt,
  output logic [31:0]           stat_conflict_cnt,
`endif
  output logic                  host_starved
);

  localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

  localparam logic [1:0] ID_H = 2'd0;
  localparam logic [1:0] ID_R = 2'd1;
  localparam logic [1:0] ID_M = 2'd2;

  logic              rr_ptr;      // 0: reservoir preferred, 1: multiplier preferred
  logic              lock_r;      // r was granted with lock last cycle
  logic              lock_m;
  logic [WAIT_W-1:0] wait_cnt;
  logic              tag_vld;
  logic [1:0]        tag_id;
  logic              lock_cont;   // this cycle's grant is a burst continuation
  logic              gnt_any;

  assign host_starved = (wait_cnt == WAIT_W'(HOST_MAX_WAIT));

  // Priority: lock owner, starved host, r/m round-robin, host.
  always_comb begin
    h_gnt     = 1'b0;
    r_gnt     = 1'b0;
    m_gnt     = 1'b0;
    lock_cont = 1'b0;
    if (!rst) begin
      if (lock_r && r_req) begin
        r_gnt     = 1'b1;
        lock_cont = 1'b1;
      end else if (lock_m && m_req) begin
        m_gnt     = 1'b1;
        lock_cont = 1'b1;
      end else if (host_starved && h_req) begin
        h_gnt = 1'b1;
      end else if (r_req && (!m_req || !rr_ptr)) begin
        r_gnt = 1'b1;
      end else if (m_req) begin
        m_gnt = 1'b1;
      end else if (h_req) begin
        h_gnt = 1'b1;
      end
    end
  end

  assign gnt_any = h_gnt | r_gnt | m_gnt;

  always_comb begin
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (h_gnt) begin
      ram_wen  = h_wen;
      ram_addr = h_addr;
      ram_din  = h_din;
    end else if (r_gnt) begin
      ram_wen  = r_wen;
      ram_addr = r_addr;
      ram_din  = r_din;
    end else if (m_gnt) begin
      ram_wen  = m_wen;
      ram_addr = m_addr;
      ram_din  = m_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      lock_r   <= 1'b0;
      lock_m   <= 1'b0;
      wait_cnt <= '0;
      tag_vld  <= 1'b0;
      tag_id   <= ID_H;
    end else begin
      // Burst continuations do not consume a round-robin turn.
      if (!lock_cont) begin
        if (r_gnt)      rr_ptr <= 1'b1;
        else if (m_gnt) rr_ptr <= 1'b0;
      end
      lock_r <= r_gnt & r_lock;
      lock_m <= m_gnt & m_lock;

      if (!h_req || h_gnt)    wait_cnt <= '0;
      else if (!host_starved) wait_cnt <= wait_cnt + 1'b1;

      // Owner tag steers next cycle's ram_dout to the right requester.
      tag_vld <= gnt_any & ~ram_wen;
      tag_id  <= h_gnt ? ID_H : (r_gnt ? ID_R : ID_M);
    end
  end

  assign h_rvalid = tag_vld && (tag_id == ID_H);
  assign r_rvalid = tag_vld && (tag_id == ID_R);
  assign m_rvalid = tag_vld && (tag_id == ID_M);
  assign rdata    = ram_dout;

`ifdef DFR_MEM_ARB_STATS_EN
  logic conflict;
  assign conflict = (h_req & r_req) | (h_req & m_req) | (r_req & m_req);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_h_cnt        <= '0;
      stat_r_cnt        <= '0;
      stat_m_cnt        <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (h_gnt && (stat_h_cnt != 32'hFFFF_FFFF))           stat_h_cnt        <= stat_h_cnt + 32'd1;
      if (r_gnt && (stat_r_cnt != 32'hFFFF_FFFF))           stat_r_cnt        <= stat_r_cnt + 32'd1;
      if (m_gnt && (stat_m_cnt != 32'hFFFF_FFFF))           stat_m_cnt        <= stat_m_cnt + 32'd1;
      if (conflict && (stat_conflict_cnt != 32'hFFFF_FFFF)) stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dfr_mem_arbiter.md
Name: dfr_mem_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency RAM between three requesters: host (AXI config-register memory window), reservoir history writer and matrix multiplier.
- Replaces static mem_sel/busy muxing in dfr_core_top, so the host can read any memory while the core runs, without corrupting core traffic.
- Internal requesters take priority over the host; an anti-starvation counter bounds host wait.
- One instance is placed per memory: input, reservoir output, output weight and DFR output.

Parameters:
- ADDR_WIDTH, 14, RAM address width.
- DATA_WIDTH, 32, RAM data width.
- HOST_MAX_WAIT, 8, cycles a pending host request may be denied before it is forced through (must be >= 1).

Ports:
- clk  in  1  system clock (S_AXI_ACLK)
- rst  in  1  synchronous, active-high reset
- h_req / r_req / m_req  in  1  access request from host / reservoir / multiplier; held until granted
- h_wen / r_wen / m_wen  in  1  1 = write, 0 = read; valid with req
- h_addr / r_addr / m_addr  in  ADDR_WIDTH  access address
- h_din / r_din / m_din  in  DATA_WIDTH  write data
- r_lock / m_lock  in  1  keep the grant on the following cycle (burst)
- h_gnt / r_gnt / m_gnt  out  1  access performed this cycle
- h_rvalid / r_rvalid / m_rvalid  out  1  rdata holds this requester's read result
- rdata  out  DATA_WIDTH  read data (ram_dout passthrough)
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, valid 1 cycle after address
- host_starved  out  1  host wait counter at HOST_MAX_WAIT

Behaviour:
- Grant is combinational from current requests and registered state. At most one gnt per cycle. The granted requester's addr/wen/din drive the RAM in the same cycle.
- With no grant: ram_wen = 0, ram_addr = 0, ram_din = 0.
- Priority order each cycle:
  1. Lock owner: previous cycle's grantee, if its lock was high last cycle and its req is still high.
  2. Host, if host_starved = 1 and h_req = 1.
  3. Round-robin between r and m. rr_ptr names the preferred one; it flips to the other after every granted r/m access that is not a lock continuation.
  4. Host.
- Lock is honoured only for r/m. It is released when the owner drops req, or drops lock in the prior cycle.
- Host starvation cannot break a lock. Host wait is bounded by lock burst length + HOST_MAX_WAIT.
- Host wait counter:
  - Increments each cycle h_req = 1 and h_gnt = 0; saturates at HOST_MAX_WAIT.
  - Clears on h_gnt, and when h_req = 0.
  - host_starved = (counter == HOST_MAX_WAIT).
- Read return:
  - A registered owner tag records {valid, id} of the read granted in cycle T.
  - In T+1 the matching x_rvalid = 1 and rdata = ram_dout.
  - Writes produce no rvalid.
  - Back-to-back reads by different requesters each get their own rvalid in consecutive cycles.
- Same-cycle read of an address written in the previous cycle returns the new data; the RAM is write-first or the access is sequential, and the arbiter adds nothing.
- Reset (synchronous):
  - rr_ptr = r, lock owner = none, wait counter = 0, read tag invalid.
  - All gnt/rvalid = 0; host_starved = 0.
  - A read granted in the cycle rst is asserted yields no rvalid.
- Requests raised while rst = 1 are ignored. Combinational grants are forced to 0 during rst.

Optional Feature:
- Macro DFR_MEM_ARB_STATS_EN.
- When defined, adds:
  - output stat_h_cnt, stat_r_cnt, stat_m_cnt (32 bits each): grants per requester.
  - output stat_conflict_cnt (32 bits): cycles with 2 or more requests high.
  - input stat_clr (1 bit): synchronous clear, which also clears on rst.
  - Counters saturate at 0xFFFFFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Solo host read of addr 0x005 holding 0xDEADBEEF:
  - h_gnt in the request cycle; h_rvalid next cycle with rdata = 0xDEADBEEF.
  - r_rvalid and m_rvalid stay 0.
- r_req and m_req held continuously, no lock, after reset: grants alternate r, m, r, m starting with r.
- h_req, r_req and m_req held continuously, HOST_MAX_WAIT = 8:
  - Host denied 8 cycles, then host_starved = 1 and h_gnt on the 9th cycle.
  - Counter returns to 0 and host_starved = 0.
- m_lock = 1 with m_req for a 5-access burst while r_req is held:
  - m_gnt for 5 consecutive cycles; r_gnt on the cycle after m_lock drops.
- Read by r at cycle T, read by m at T+1:
  - r_rvalid at T+1 and m_rvalid at T+2, each with its own RAM word.
  - No rvalid at T+2 if rst is asserted at T+1.
- Stats build: 3 host grants and 4 conflict cycles give stat_h_cnt = 3 and stat_conflict_cnt = 4; stat_clr returns both to 0 next cycle.
